// File: rtl/resp_misr.sv
// resp_misr: response compactor. Folds one DUT response word per accepted
// handshake into a multiple-input signature register (MISR). After NPAT
// accepts it freezes and presents the final signature.
//
// Optional feature macro: MISR_GOLDEN_CMP_EN
//   defined   - golden comparator plus registered pass flag are built
//   undefined - pass tied to 0, golden ignored
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   start             single-cycle pulse beginning a run (ignored in RUN)
//   resp_valid/ready  response handshake; resp_data is the DUT response word
//   golden            expected signature
//   busy, done        run in progress / run complete (signature frozen)
//   pass              signature matched golden; meaningful while done=1
//   pat_count         responses accepted in the current run
//   signature         current MISR value
module resp_misr #(
  parameter int               WIDTH = 1,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021,
  parameter logic [SIG_W-1:0] SEED  = '0,
  parameter int               NPAT  = 256,
  localparam int              CW    = $clog2(NPAT+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_data,
  output logic             resp_ready,
  input  logic [SIG_W-1:0] golden,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CW-1:0]    pat_count,
  output logic [SIG_W-1:0] signature
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic             load, acc, last;
  logic [SIG_W-1:0] sig_nxt;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    // resp_ready is a flop decoded from state, so no path from resp_valid
    acc       = resp_valid && resp_ready;
    last      = acc && (pat_count == CW'(NPAT-1));
    sig_nxt   = {signature[SIG_W-2:0], 1'b0}
              ^ (signature[SIG_W-1] ? POLY : '0)
              ^ SIG_W'(resp_data);
    case (state)
      IDLE, DONE: if (start) begin
        state_nxt = RUN;
        load      = 1'b1;
      end
      RUN: if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pat_count  <= '0;
      signature  <= SEED;
    end else begin
      state      <= state_nxt;
      // status flags registered from the next state so they line up with it
      resp_ready <= (state_nxt == RUN);
      busy       <= (state_nxt == RUN);
      done       <= (state_nxt == DONE);
      if (load) begin
        pat_count <= '0;
        signature <= SEED;
      end else if (acc) begin
        pat_count <= pat_count + CW'(1);
        signature <= sig_nxt;
      end
    end
  end

`ifdef MISR_GOLDEN_CMP_EN
  // compare the signature being written on the final accept, not the old one
  always_ff @(posedge clk) begin
    if (!rst_n)     pass <= 1'b0;
    else if (load)  pass <= 1'b0;
    else if (last)  pass <= (sig_nxt == golden);
  end
`else
  logic unused_golden;
  assign unused_golden = ^golden;
  assign pass          = 1'b0;
`endif

endmodule

// File: tb/tb_resp_misr.sv
// Bench for resp_misr: two instances (NPAT=4 and NPAT=1) share one stimulus
// stream; a behavioural model per instance predicts every output each cycle.
module tb_resp_misr;
  localparam int SW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, resp_valid;
  logic [0:0]    resp_data;
  logic [SW-1:0] golden;

  logic          rdy0, busy0, done0, pass0;
  logic [2:0]    pc0;
  logic [SW-1:0] sig0;
  logic          rdy1, busy1, done1, pass1;
  logic [0:0]    pc1;
  logic [SW-1:0] sig1;

  resp_misr #(.WIDTH(1), .SIG_W(SW), .POLY(4'h3), .SEED(4'h0), .NPAT(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_ready(rdy0), .golden(golden), .busy(busy0),
    .done(done0), .pass(pass0), .pat_count(pc0), .signature(sig0));

  resp_misr #(.WIDTH(1), .SIG_W(SW), .POLY(4'h3), .SEED(4'h0), .NPAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_ready(rdy1), .golden(golden), .busy(busy1),
    .done(done1), .pass(pass1), .pat_count(pc1), .signature(sig1));

`ifdef MISR_GOLDEN_CMP_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  // model: 0=idle 1=run 2=done
  int m_st[2], m_sig[2], m_cnt[2], m_pass[2];
  int npat[2] = '{4, 1};

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // signature polynomial step in plain integer arithmetic (mod 2^SW)
  function automatic int fold(int s, int d);
    int r;
    r = (s * 2) % 16;
    if (s >= 8) r = r ^ 3;
    return r ^ d;
  endfunction

  task automatic model_edge(int k);
    if (!rst_n) begin
      m_st[k] = 0; m_sig[k] = 0; m_cnt[k] = 0; m_pass[k] = 0;
    end else if (m_st[k] != 1) begin
      if (start) begin
        m_st[k] = 1; m_sig[k] = 0; m_cnt[k] = 0; m_pass[k] = 0;
      end
    end else if (resp_valid) begin
      m_sig[k] = fold(m_sig[k], int'(resp_data));
      m_cnt[k]++;
      if (m_cnt[k] == npat[k]) begin
        m_st[k]   = 2;
        m_pass[k] = (CMP && m_sig[k] == int'(golden)) ? 1 : 0;
      end
    end
  endtask

  task automatic cyc();
    model_edge(0);
    model_edge(1);
    @(posedge clk); #1;
    chk("u0.sig",  32'(sig0),  32'(m_sig[0]));
    chk("u0.cnt",  32'(pc0),   32'(m_cnt[0]));
    chk("u0.busy", 32'(busy0), 32'(m_st[0] == 1));
    chk("u0.rdy",  32'(rdy0),  32'(m_st[0] == 1));
    chk("u0.done", 32'(done0), 32'(m_st[0] == 2));
    chk("u0.pass", 32'(pass0), 32'(m_pass[0]));
    chk("u1.sig",  32'(sig1),  32'(m_sig[1]));
    chk("u1.cnt",  32'(pc1),   32'(m_cnt[1]));
    chk("u1.busy", 32'(busy1), 32'(m_st[1] == 1));
    chk("u1.done", 32'(done1), 32'(m_st[1] == 2));
    chk("u1.pass", 32'(pass1), 32'(m_pass[1]));
  endtask

  task automatic drv(bit r, bit s, bit v, bit d);
    rst_n = r; start = s; resp_valid = v; resp_data = d;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; resp_valid = 1'b0; resp_data = 1'b0;
    golden = 4'hB;
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_sig[k] = 0; m_cnt[k] = 0; m_pass[k] = 0;
    end
    #1;

    // reset
    drv(0, 0, 0, 0);
    drv(0, 0, 0, 0);
    chk("rst.sig",  32'(sig0),  32'h0);
    chk("rst.cnt",  32'(pc0),   32'h0);
    chk("rst.busy", 32'(busy0), 32'h0);
    chk("rst.done", 32'(done0), 32'h0);
    chk("rst.rdy",  32'(rdy0),  32'h0);
    chk("rst.pass", 32'(pass0), 32'h0);
    drv(1, 0, 1, 1);  // valid in IDLE must be ignored
    chk("idle.cnt", 32'(pc0), 32'h0);

    // basic run 1,0,1,1 -> 1,2,5,B
    drv(1, 1, 0, 0);
    chk("start.busy", 32'(busy0), 32'h1);
    drv(1, 0, 1, 1);
    chk("b1.sig", 32'(sig0), 32'h1);
    chk("n1.done", 32'(done1), 32'h1);
    chk("n1.sig",  32'(sig1),  32'h1);
    drv(1, 0, 1, 0);
    chk("b2.sig", 32'(sig0), 32'h2);
    drv(1, 0, 1, 1);
    chk("b3.sig", 32'(sig0), 32'h5);
    chk("b3.done", 32'(done0), 32'h0);
    drv(1, 0, 1, 1);
    chk("b4.sig",  32'(sig0),  32'hB);
    chk("b4.cnt",  32'(pc0),   32'h4);
    chk("b4.done", 32'(done0), 32'h1);
    chk("b4.pass", 32'(pass0), 32'(CMP));
    drv(1, 0, 1, 0);  // frozen in DONE
    chk("frz.sig", 32'(sig0), 32'hB);
    chk("frz.cnt", 32'(pc0),  32'h4);

    // restart from DONE, stalls, ignored mid-run start, wrong golden
    golden = 4'hA;
    drv(1, 1, 0, 0);
    chk("rs.sig",  32'(sig0),  32'h0);
    chk("rs.cnt",  32'(pc0),   32'h0);
    chk("rs.done", 32'(done0), 32'h0);
    chk("rs.busy", 32'(busy0), 32'h1);
    chk("rs.pass", 32'(pass0), 32'h0);
    drv(1, 0, 0, 1);
    drv(1, 0, 1, 1);
    drv(1, 0, 0, 0);
    drv(1, 1, 1, 0);  // start while RUN: accept proceeds, no restart
    drv(1, 0, 0, 1);
    drv(1, 0, 1, 1);
    drv(1, 0, 0, 0);
    drv(1, 0, 1, 1);
    chk("st.sig",  32'(sig0),  32'hB);
    chk("st.cnt",  32'(pc0),   32'h4);
    chk("st.done", 32'(done0), 32'h1);
    chk("st.pass", 32'(pass0), 32'h0);

    // reset mid-run
    golden = 4'hB;
    drv(1, 1, 0, 0);
    drv(1, 0, 1, 1);
    drv(1, 0, 1, 0);
    drv(0, 0, 0, 0);
    chk("mr.sig",  32'(sig0),  32'h0);
    chk("mr.cnt",  32'(pc0),   32'h0);
    chk("mr.busy", 32'(busy0), 32'h0);
    chk("mr.rdy",  32'(rdy0),  32'h0);
    chk("mr.done", 32'(done0), 32'h0);
    drv(1, 1, 0, 0);
    drv(1, 0, 1, 1);
    drv(1, 0, 1, 0);
    drv(1, 0, 1, 1);
    drv(1, 0, 1, 1);
    chk("mr2.sig",  32'(sig0),  32'hB);
    chk("mr2.pass", 32'(pass0), 32'(CMP));

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      golden = 4'($urandom_range(0, 15));
      drv(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/resp_misr.md
# resp_misr

Response compactor placed directly downstream of the fault-simulated device under test. It consumes one DUT response word per accepted handshake and folds it into a multiple-input signature register (MISR). After a programmed number of patterns it freezes and presents the final signature. Optionally, it compares that signature against a golden value and flags pass/fail for the fault-grading flow.

## Interface
Parameters:
- WIDTH, 1, response word width; must be ≤ SIG_W
- SIG_W, 16, signature width
- POLY, 16'h1021, feedback polynomial taps, SIG_W bits wide
- SEED, 0, signature value loaded at reset and on start
- NPAT, 256, number of responses compacted per run; NPAT ≥ 1

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- start  in  1  single-cycle pulse that begins a run
- resp_valid  in  1  response word present
- resp_data  in  WIDTH  DUT response word
- resp_ready  out  1  block accepts a response this cycle
- golden  in  SIG_W  expected signature
- busy  out  1  run in progress
- done  out  1  run complete; signature frozen
- pass  out  1  signature equals golden; valid only while done=1
- pat_count  out  $clog2(NPAT+1)  number of responses accepted in the current run
- signature  out  SIG_W  current MISR value

## Operation
- FSM states:
  - IDLE: resp_ready=0.
  - RUN: resp_ready=1, busy=1.
  - DONE: done=1, resp_ready=0.
- Transitions:
  - IDLE→RUN on start. Same edge: signature←SEED, pat_count←0.
  - RUN→DONE on the edge that accepts response number NPAT.
  - DONE→RUN on start. Reload as for IDLE→RUN.
  - start is ignored while in RUN.
- Accept occurs when resp_valid && resp_ready. Only accepts update state.
- MISR update on accept: sig ← {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extend(resp_data).
- On accept, pat_count increments by 1. It never exceeds NPAT and holds its value in DONE.
- When resp_valid=0 in RUN, signature and pat_count hold.
- Reset values (rst_n=0 at a clock edge): state=IDLE, signature=SEED, pat_count=0, busy=0, done=0, pass=0, resp_ready=0.
- Reset asserted mid-run aborts the run. No partial result is retained.

## Timing
- All outputs are registered.
- resp_ready depends only on state; it has no combinational path from resp_valid.
- start is sampled at a clock edge. busy and resp_ready go high in the following cycle.
- The first response can be accepted in the cycle after start.
- done rises in the cycle after the NPAT-th accept. It stays high until the next start or reset.
- pass is registered on the RUN→DONE edge from the final signature and golden. It is cleared on start.
- Throughput: one response per clock in RUN.
- NPAT=1: a single accept moves the FSM RUN→DONE.

## Configuration
- MISR_GOLDEN_CMP_EN defined:
  - The golden comparator and the pass register are built.
  - pass=1 in DONE iff signature==golden as registered on the RUN→DONE edge; otherwise 0.
- MISR_GOLDEN_CMP_EN undefined:
  - No comparator is built.
  - pass is tied to 0 and golden is ignored.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=1, SIG_W=4, POLY=4'h3, SEED=0, NPAT=4 unless noted.
- Reset: hold rst_n=0 for 2 clocks → signature=0, pat_count=0, busy=0, done=0, resp_ready=0, pass=0.
- Basic run: start, then responses 1,0,1,1 on consecutive clocks → signature sequence 1,2,5,B. done rises the cycle after the 4th accept, with pat_count=4 and signature=4'hB.
- Stalls and ignored start: same data with resp_valid=0 gaps inserted, plus a start pulse mid-run → final signature=4'hB, pat_count=4, and the run is not restarted.
- Golden compare (macro defined): golden=4'hB → pass=1. golden=4'hA → pass=0. Without the macro → pass=0 in both cases.
- Reset mid-run: rst_n=0 after 2 accepts → all outputs return to reset values. Then start plus 4 responses → signature=4'hB.
- Restart and NPAT=1 (restart from DONE, then NPAT=1 variant): start after done → signature=0, pat_count=0, done=0, busy=1. With NPAT=1, a single accept of 1 → done=1, signature=4'h1.
